// File: rtl/aha_reload_down_counter_pkg.sv
// aha_reload_down_counter_pkg: state and mode encodings shared by the timer block
package aha_reload_down_counter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;
endpackage

// File: rtl/aha_reload_down_counter.sv
// aha_reload_down_counter: loadable down-counter with one-shot/auto-reload and a terminal-count pulse
module aha_reload_down_counter
  import aha_reload_down_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             periodic_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] reload_o,
  output logic             running_o,
  output logic             zero_o,
  output logic             expired_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d, reload_q, reload_d;
  logic             expired_q, expired_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ONESHOT;
      q_q       <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      q_q       <= q_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end
  // CLR beats LOAD beats counting; a zero load parks the timer in IDLE
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    q_d       = q_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (clr_i) begin
      state_d = ST_IDLE;
      q_d     = '0;
    end else if (load_i) begin
      q_d      = load_val_i;
      reload_d = load_val_i;
      if (load_val_i != '0) begin
        mode_d  = mode_e'(periodic_i);
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en_i) begin
            if (q_q == ONE) begin
              expired_d = 1'b1;
              q_d       = (mode_q == MODE_PERIODIC) ? reload_q : '0;
              state_d   = (mode_q == MODE_PERIODIC) ? ST_RUN : ST_DONE;
            end else begin
              q_d = q_q - ONE;
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: begin
          state_d = ST_IDLE;
          q_d     = '0;
        end
      endcase
    end
  end
  assign q_o       = q_q;
  assign reload_o  = reload_q;
  assign running_o = (state_q == ST_RUN);
  assign zero_o    = (q_q == '0);
  assign expired_o = expired_q;
endmodule

// File: tb/tb_aha_reload_down_counter.sv
// tb_aha_reload_down_counter: scoreboard bench for the reload down-counter
module tb_aha_reload_down_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, load = 1'b0, periodic = 1'b0, clr = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] q, reload;
  logic       running, zero, expired;
  int         n_checks = 0, n_errs = 0;
  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       run;
    logic       zero;
    logic       exp;
  } exp_t;
  exp_t sb[$];
  int m_state = 0;
  int m_q = 0, m_r = 0;
  bit m_per = 0, m_exp = 0;
  int pulses, first;
  bit saw_zero;
  aha_reload_down_counter #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .load_val_i(load_val),
    .periodic_i(periodic), .clr_i(clr), .q_o(q), .reload_o(reload),
    .running_o(running), .zero_o(zero), .expired_o(expired)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input bit e, input bit ld, input int v, input bit per, input bit c);
    exp_t x;
    @(negedge clk);
    en = e; load = ld; load_val = 8'(v); periodic = per; clr = c;
    m_exp = 0;
    if (c) begin
      m_state = 0; m_q = 0;
    end else if (ld) begin
      m_q = v; m_r = v;
      if (v != 0) begin m_per = per; m_state = 1; end
      else m_state = 0;
    end else if (m_state == 1 && e) begin
      if (m_q == 1) begin
        m_exp = 1;
        if (m_per) m_q = m_r;
        else begin m_q = 0; m_state = 2; end
      end else m_q = m_q - 1;
    end
    x.q = 8'(m_q); x.r = 8'(m_r); x.run = (m_state == 1); x.zero = (m_q == 0); x.exp = m_exp;
    sb.push_back(x);
    @(posedge clk);
    #1;
    en = 0; load = 0; clr = 0;
    x = sb.pop_front();
    check("q", q, x.q);
    check("reload", reload, x.r);
    check("running", running, x.run);
    check("zero", zero, x.zero);
    check("expired", expired, x.exp);
    if (expired) pulses++;
    if (zero) saw_zero = 1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_running", running, 0);
    check("rst_zero", zero, 1);
    check("rst_expired", expired, 0);
    @(negedge clk) rst_n = 1;
    // async reset mid-run
    step(0, 1, 5, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check("arst_q", q, 0);
    check("arst_running", running, 0);
    check("arst_expired", expired, 0);
    check("arst_zero", zero, 1);
    m_state = 0; m_q = 0; m_r = 0; m_per = 0;
    @(negedge clk) rst_n = 1;
    // one-shot
    pulses = 0;
    step(0, 1, 3, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0);
    check("oneshot_pulses", pulses, 1);
    // periodic
    step(0, 1, 4, 1, 0);
    pulses = 0; saw_zero = 0;
    repeat (12) step(1, 0, 0, 0, 0);
    check("periodic_pulses", pulses, 3);
    check("periodic_zero", saw_zero, 0);
    // EN gaps
    step(0, 1, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // collisions
    step(0, 1, 2, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 9, 1, 1);
    step(0, 1, 6, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // expiry followed immediately by CLR
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    // width edge
    step(0, 1, 255, 1, 0);
    first = 0;
    for (int i = 1; i <= 300 && first == 0; i++) begin
      step(1, 0, 0, 0, 0);
      if (expired) first = i;
    end
    check("wrap_cycles", first, 255);
    check("wrap_q", q, 255);
    check("wrap_reload", reload, 255);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
